// File: rtl/pipe_hazard_if.sv
// Hazard-controller bus: decode/X/WB control fields in, stall/flush/forward controls out.
// master = pipeline side driving the fields, slave = hazard controller.
interface pipe_hazard_if;
   logic [4:0] rs1_d;
   logic [4:0] rs2_d;
   logic       rs1_use_d;
   logic       rs2_use_d;
   logic [4:0] rd_x;
   logic       reg_we_x;
   logic [1:0] wb_sel_x;
   logic       pc_sel_x;
   logic [4:0] rd_w;
   logic       reg_we_w;
   logic       dmem_busy;
   logic       stall_f;
   logic       stall_x;
   logic       bubble_x;
   logic       flush_d;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   modport master (
      output rs1_d, rs2_d, rs1_use_d, rs2_use_d, rd_x, reg_we_x, wb_sel_x,
             pc_sel_x, rd_w, reg_we_w, dmem_busy,
      input  stall_f, stall_x, bubble_x, flush_d, fwd_a, fwd_b
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_use_d, rs2_use_d, rd_x, reg_we_x, wb_sel_x,
             pc_sel_x, rd_w, reg_we_w, dmem_busy,
      output stall_f, stall_x, bubble_x, flush_d, fwd_a, fwd_b
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 3-stage core (IF/D -> X -> WB): load-use stall,
// DMEM wait freeze, redirect flush and ALU operand forwarding.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter logic [1:0]  WB_MEM      = 2'd0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 7 || CNT_W < 1) begin : g_param_err
      $error("pipe_hazard_ctrl: FLUSH_DEPTH must be 1..7 and CNT_W >= 1");
   end

   typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, REDIR} state_e;

   state_e     state_q, state_d;
   logic [2:0] redir_cnt_q, redir_cnt_d;
   logic       load_use;
   logic       eval_run;
   logic       stall_f, stall_x, bubble_x, flush_d;
   logic [1:0] fwd_a, fwd_b;

   // State and redirect counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         redir_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   // Next state and hazard controls; MEM_WAIT exit falls through to RUN evaluation
   always_comb begin
      state_d     = state_q;
      redir_cnt_d = redir_cnt_q;
      stall_f     = 1'b0;
      stall_x     = 1'b0;
      bubble_x    = 1'b0;
      flush_d     = 1'b0;
      eval_run    = 1'b0;
      load_use    = (hz.wb_sel_x == WB_MEM) && hz.reg_we_x && (hz.rd_x != 5'd0) &&
                    ((hz.rs1_use_d && (hz.rs1_d == hz.rd_x)) ||
                     (hz.rs2_use_d && (hz.rs2_d == hz.rd_x)));
      case (state_q)
         RUN:      eval_run = 1'b1;
         LD_STALL: state_d  = RUN;
         MEM_WAIT: begin
            if (hz.dmem_busy) begin
               stall_f = 1'b1;
               stall_x = 1'b1;
            end else begin
               eval_run = 1'b1;
            end
         end
         REDIR: begin
            if (hz.dmem_busy) begin
               stall_f = 1'b1;
               stall_x = 1'b1;
            end else begin
               flush_d     = 1'b1;
               bubble_x    = 1'b1;
               redir_cnt_d = redir_cnt_q - 3'd1;
               if (redir_cnt_q == 3'd1) state_d = RUN;
            end
         end
         default:  state_d = RUN;
      endcase
      if (eval_run) begin
         state_d = RUN;
         if (hz.dmem_busy) begin
            stall_f = 1'b1;
            stall_x = 1'b1;
            state_d = MEM_WAIT;
         end else if (hz.pc_sel_x) begin
            flush_d  = 1'b1;
            bubble_x = 1'b1;
            if (FLUSH_DEPTH > 1) begin
               redir_cnt_d = 3'(FLUSH_DEPTH - 1);
               state_d     = REDIR;
            end
         end else if (load_use) begin
            stall_f  = 1'b1;
            bubble_x = 1'b1;
            state_d  = LD_STALL;
         end
      end
      if (!rst_n) begin
         stall_f  = 1'b0;
         stall_x  = 1'b0;
         flush_d  = 1'b0;
         bubble_x = 1'b1;
      end
   end

   // Operand forwarding: X result beats WB result, x0 never forwards, loads in X cannot forward
   always_comb begin
      fwd_a = 2'd0;
      fwd_b = 2'd0;
      if (hz.reg_we_x && (hz.rd_x != 5'd0) && (hz.rd_x == hz.rs1_d) && (hz.wb_sel_x != WB_MEM))
         fwd_a = 2'd1;
      else if (hz.reg_we_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_d))
         fwd_a = 2'd2;
      if (hz.reg_we_x && (hz.rd_x != 5'd0) && (hz.rd_x == hz.rs2_d) && (hz.wb_sel_x != WB_MEM))
         fwd_b = 2'd1;
      else if (hz.reg_we_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_d))
         fwd_b = 2'd2;
      if (!rst_n) begin
         fwd_a = 2'd0;
         fwd_b = 2'd0;
      end
   end

   assign hz.stall_f  = stall_f;
   assign hz.stall_x  = stall_x;
   assign hz.bubble_x = bubble_x;
   assign hz.flush_d  = flush_d;
   assign hz.fwd_a    = fwd_a;
   assign hz.fwd_b    = fwd_b;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // A redirect event is a flush raised outside REDIR (only pc_sel_x does that)
   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush_d && (state_q != REDIR));
   end

   // Performance counter registers, wrapping modulo 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
   localparam int unsigned FLUSH_DEPTH = 2;
   localparam logic [1:0]  WB_MEM      = 2'd0;
   localparam int unsigned CNT_W       = 32;

   logic clk = 1'b0;
   logic rst_n;
   pipe_hazard_if hif();
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

   pipe_hazard_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH), .WB_MEM(WB_MEM), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hz        (hif.slave)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: remaining flush cycles after a redirect, pending load shadow cycle
   int               m_flush_left, n_flush_left;
   bit               m_ld_shadow, n_ld_shadow;
   logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt;
   logic             e_stall_f, e_stall_x, e_bubble_x, e_flush_d, e_redir_ev;
   logic [1:0]       e_fwd_a, e_fwd_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (!rst_n) return 2'd0;
      if (hif.reg_we_x && hif.rd_x != 0 && hif.rd_x == rs && hif.wb_sel_x != WB_MEM) return 2'd1;
      if (hif.reg_we_w && hif.rd_w != 0 && hif.rd_w == rs) return 2'd2;
      return 2'd0;
   endfunction

   task automatic predict();
      bit lu;
      lu = (hif.wb_sel_x == WB_MEM) && hif.reg_we_x && (hif.rd_x != 0) &&
           ((hif.rs1_use_d && hif.rs1_d == hif.rd_x) || (hif.rs2_use_d && hif.rs2_d == hif.rd_x));
      {e_stall_f, e_stall_x, e_bubble_x, e_flush_d, e_redir_ev} = '0;
      n_flush_left = m_flush_left;
      n_ld_shadow  = 0;
      if (!rst_n) begin
         e_bubble_x   = 1;
         n_flush_left = 0;
      end else if (m_ld_shadow) begin
         // shadow cycle after a load-use stall: nothing asserted
      end else if (m_flush_left > 0) begin
         if (hif.dmem_busy) begin
            e_stall_f = 1; e_stall_x = 1;
         end else begin
            e_flush_d = 1; e_bubble_x = 1;
            n_flush_left = m_flush_left - 1;
         end
      end else if (hif.dmem_busy) begin
         e_stall_f = 1; e_stall_x = 1;
      end else if (hif.pc_sel_x) begin
         e_flush_d = 1; e_bubble_x = 1; e_redir_ev = 1;
         n_flush_left = FLUSH_DEPTH - 1;
      end else if (lu) begin
         e_stall_f = 1; e_bubble_x = 1;
         n_ld_shadow = 1;
      end
      e_fwd_a = fwd_ref(hif.rs1_d);
      e_fwd_b = fwd_ref(hif.rs2_d);
   endtask

   task automatic check_all();
      predict();
      chk("stall_f",  hif.stall_f,  e_stall_f);
      chk("stall_x",  hif.stall_x,  e_stall_x);
      chk("bubble_x", hif.bubble_x, e_bubble_x);
      chk("flush_d",  hif.flush_d,  e_flush_d);
      chk("fwd_a",    hif.fwd_a,    e_fwd_a);
      chk("fwd_b",    hif.fwd_b,    e_fwd_b);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall_cnt);
      chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif
   endtask

   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      #1;
      m_flush_left = n_flush_left;
      m_ld_shadow  = n_ld_shadow;
      m_stall_cnt  = m_stall_cnt + CNT_W'(e_stall_f);
      m_flush_cnt  = m_flush_cnt + CNT_W'(e_redir_ev);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      m_flush_left = 0;
      m_ld_shadow  = 0;
      m_stall_cnt  = '0;
      m_flush_cnt  = '0;
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic clear_in();
      hif.rs1_d = 0; hif.rs2_d = 0; hif.rs1_use_d = 0; hif.rs2_use_d = 0;
      hif.rd_x = 0; hif.reg_we_x = 0; hif.wb_sel_x = 2'd1; hif.pc_sel_x = 0;
      hif.rd_w = 0; hif.reg_we_w = 0; hif.dmem_busy = 0;
   endtask

   task automatic rand_in();
      hif.rs1_d     = 5'($urandom_range(0, 3));
      hif.rs2_d     = 5'($urandom_range(0, 3));
      hif.rs1_use_d = 1'($urandom_range(0, 1));
      hif.rs2_use_d = 1'($urandom_range(0, 1));
      hif.rd_x      = 5'($urandom_range(0, 3));
      hif.reg_we_x  = 1'($urandom_range(0, 1));
      hif.wb_sel_x  = 2'($urandom_range(0, 3));
      hif.pc_sel_x  = ($urandom_range(0, 7) == 0);
      hif.rd_w      = 5'($urandom_range(0, 3));
      hif.reg_we_w  = 1'($urandom_range(0, 1));
      hif.dmem_busy = ($urandom_range(0, 5) == 0);
   endtask

   initial begin
      clear_in();
      do_reset();

      // load x5 in X, decode reads rs1=x5: one stall cycle, then WB forward
      hif.rd_x = 5; hif.reg_we_x = 1; hif.wb_sel_x = WB_MEM; hif.rs1_d = 5; hif.rs1_use_d = 1;
      #1;
      chk("t1_stall_f", hif.stall_f, 1'b1);
      chk("t1_bubble_x", hif.bubble_x, 1'b1);
      step();
      hif.reg_we_x = 0; hif.rd_x = 0; hif.rd_w = 5; hif.reg_we_w = 1;
      #1;
      chk("t1_fwd_a_wb", hif.fwd_a, 2'd2);
      chk("t1_no_stall", hif.stall_f, 1'b0);
      step();
      clear_in();

      // redirect: two cycles of flush then back to run
      hif.pc_sel_x = 1;
      step();
      hif.pc_sel_x = 0;
      #1;
      chk("t3_flush_2nd", hif.flush_d, 1'b1);
      step();
      #1;
      chk("t3_flush_done", hif.flush_d, 1'b0);
      step();
`ifdef HAZARD_PERF_CNT_EN
      chk("t6_stall_cnt", stall_cnt, 32'd1);
      chk("t6_flush_cnt", flush_cnt, 32'd1);
`endif

      // ALU result x7 in X and WB: X wins; x0 never forwards
      hif.rd_x = 7; hif.reg_we_x = 1; hif.wb_sel_x = 2'd1; hif.rs2_d = 7; hif.rs2_use_d = 1;
      hif.rd_w = 7; hif.reg_we_w = 1;
      #1;
      chk("t2_fwd_b_x", hif.fwd_b, 2'd1);
      step();
      hif.rd_x = 0; hif.rd_w = 0; hif.rs2_d = 0;
      #1;
      chk("t2_fwd_b_x0", hif.fwd_b, 2'd0);
      step();
      clear_in();

      // DMEM busy 3 cycles with redirect held: freeze then flush
      hif.pc_sel_x = 1; hif.dmem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_stall_x", hif.stall_x, 1'b1);
         chk("t4_no_flush", hif.flush_d, 1'b0);
         step();
      end
      hif.dmem_busy = 0;
      #1;
      chk("t4_flush", hif.flush_d, 1'b1);
      step();
      hif.pc_sel_x = 0;
      step();
      step();

      // reset in the middle of a redirect
      hif.pc_sel_x = 1;
      step();
      clear_in();
      do_reset();
      #1;
      chk("t5_no_flush", hif.flush_d, 1'b0);
      chk("t5_no_bubble", hif.bubble_x, 1'b0);
      step();

      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rand_in();
         if ($urandom_range(0, 99) == 0) do_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
